// File: rtl/mutex_rule_scheduler_if.sv
// Rule-scheduler bundle: guard/run/step toward the scheduler and the
// rule enable plus status back toward the Murphi system and debug host.
interface mutex_rule_scheduler_if #(
    parameter int NUM_RULES = 4,
    parameter int CNT_W     = 16
);
    logic [NUM_RULES-1:0] io_guard;
    logic                 io_run;
    logic                 io_step;
    logic [NUM_RULES-1:0] io_en_a;
    logic [CNT_W-1:0]     io_fired_count;
    logic                 io_deadlock;
    logic [1:0]           io_state;

    modport master (
        input  io_guard,
        input  io_run,
        input  io_step,
        output io_en_a,
        output io_fired_count,
        output io_deadlock,
        output io_state
    );

    modport slave (
        output io_guard,
        output io_run,
        output io_step,
        input  io_en_a,
        input  io_fired_count,
        input  io_deadlock,
        input  io_state
    );
endinterface

// File: rtl/mutex_rule_scheduler.sv
// Fair round-robin rule-firing driver for a Murphi system block, with
// halt/single-step debug, saturating fire counter and sticky deadlock detect.
module mutex_rule_scheduler #(
    parameter int NUM_RULES      = 4,
    parameter int CNT_W          = 16,
    parameter int DEADLOCK_LIMIT = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    mutex_rule_scheduler_if.master sched
);
    localparam int PTR_W  = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
    localparam int IDLE_W = $clog2(DEADLOCK_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [IDLE_W-1:0] idle_cnt;
    logic [CNT_W-1:0]  fired_cnt;

    logic              cand_found;
    logic [PTR_W-1:0]  cand_idx;
    logic [PTR_W:0]    probe;
    logic              grant_ok;
    logic              grant;
    logic              guard_idle;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_RULES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Scan offsets from farthest to nearest so the last hit is the first
    // enabled rule at or after ptr, with wrap.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        probe      = '0;
        for (int off = NUM_RULES - 1; off >= 0; off--) begin
            probe = {1'b0, ptr} + (PTR_W + 1)'(off);
            if (probe >= (PTR_W + 1)'(NUM_RULES))
                probe = probe - (PTR_W + 1)'(NUM_RULES);
            if (sched.io_guard[probe[PTR_W-1:0]]) begin
                cand_found = 1'b1;
                cand_idx   = probe[PTR_W-1:0];
            end
        end
    end

    // Gating by reset keeps the enable low the instant reset asserts, even
    // if a step pulse is present while the state is forced to HALT.
    always_comb begin
        grant_ok = 1'b0;
        case (state)
            ST_RUN:  grant_ok = 1'b1;
            ST_HALT: grant_ok = sched.io_step;
            default: grant_ok = 1'b0;
        endcase
    end

    assign grant      = reset & grant_ok & cand_found;
    assign guard_idle = ~|sched.io_guard;

    assign sched.io_en_a        = grant ? (NUM_RULES'(1) << cand_idx) : '0;
    assign sched.io_fired_count = fired_cnt;
    assign sched.io_deadlock    = (state == ST_DEAD);
    assign sched.io_state       = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_HALT;
            ptr       <= '0;
            idle_cnt  <= '0;
            fired_cnt <= '0;
        end else begin
            if (grant) begin
                ptr       <= wrap_inc(cand_idx);
                fired_cnt <= sat_inc(fired_cnt);
            end
            case (state)
                ST_HALT: begin
                    idle_cnt <= '0;
                    if (sched.io_run)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    // Deadlock wins over a simultaneous drop of io_run.
                    if (guard_idle && idle_cnt == IDLE_W'(DEADLOCK_LIMIT - 1)) begin
                        state    <= ST_DEAD;
                        idle_cnt <= '0;
                    end else if (!sched.io_run) begin
                        state    <= ST_HALT;
                        idle_cnt <= '0;
                    end else if (guard_idle) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                ST_DEAD: begin
                    idle_cnt <= '0;
                end
                default: begin
                    state    <= ST_HALT;
                    idle_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mutex_rule_scheduler.sv
// Directed + random bench for mutex_rule_scheduler against a rule-level model.
module tb_mutex_rule_scheduler;
    localparam int N     = 4;
    localparam int LIMIT = 8;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] guard = 4'b0;
    logic       run   = 1'b0;
    logic       step  = 1'b0;

    int total = 0;
    int bad   = 0;

    // model state: mode 0=HALT 1=RUN 2=DEAD
    int m_mode = 0;
    int m_ptr  = 0;
    int m_idle = 0;
    int m_cnt  = 0;

    always #5 clock = ~clock;

    mutex_rule_scheduler_if #(.NUM_RULES(N), .CNT_W(16)) mif ();
    mutex_rule_scheduler_if #(.NUM_RULES(N), .CNT_W(4))  sif ();

    assign mif.io_guard = guard;
    assign mif.io_run   = run;
    assign mif.io_step  = step;
    assign sif.io_guard = guard;
    assign sif.io_run   = run;
    assign sif.io_step  = step;

    mutex_rule_scheduler #(.NUM_RULES(N), .CNT_W(16), .DEADLOCK_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (rst_n),
        .sched (mif)
    );

    mutex_rule_scheduler #(.NUM_RULES(N), .CNT_W(4), .DEADLOCK_LIMIT(LIMIT)) dut_sat (
        .clock (clock),
        .reset (rst_n),
        .sched (sif)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int model_grant(input logic [3:0] g, input logic s);
        bit allowed;
        if (!rst_n) return -1;
        allowed = (m_mode == 1) || (m_mode == 0 && s);
        if (!allowed) return -1;
        for (int k = 0; k < N; k++) begin
            if (g[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [3:0] g, input logic r, input int k);
        if (k >= 0) begin
            m_ptr = (k + 1) % N;
            m_cnt++;
        end
        case (m_mode)
            0: if (r) m_mode = 1;
            1: begin
                if (g == 4'b0) m_idle++;
                else m_idle = 0;
                if (m_idle >= LIMIT) begin
                    m_mode = 2;
                    m_idle = 0;
                end else if (!r) begin
                    m_mode = 0;
                    m_idle = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_ptr  = 0;
        m_idle = 0;
        m_cnt  = 0;
    endtask

    task automatic check_all(input int k);
        logic [3:0] exp_en;
        exp_en = (k < 0) ? 4'b0 : 4'(1 << k);
        check("en_a", 32'(mif.io_en_a), 32'(exp_en));
        check("state", 32'(mif.io_state), 32'(m_mode));
        check("deadlock", 32'(mif.io_deadlock), 32'(m_mode == 2));
        check("fired_count", 32'(mif.io_fired_count), 32'((m_cnt > 65535) ? 65535 : m_cnt));
        check("sat_count", 32'(sif.io_fired_count), 32'((m_cnt > 15) ? 15 : m_cnt));
        check("sat_en_a", 32'(sif.io_en_a), 32'(exp_en));
    endtask

    // Drive one cycle: inputs just after posedge, check mid-cycle, advance model at edge.
    task automatic cycle(input logic [3:0] g, input logic r, input logic s);
        int k;
        guard = g;
        run   = r;
        step  = s;
        @(negedge clock);
        k = model_grant(g, s);
        check_all(k);
        @(posedge clock);
        if (rst_n) model_update(g, r, k);
        #1;
    endtask

    initial begin
        // reset held with everything asking to run
        for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1, 1'b1);
        check("reset_count", 32'(mif.io_fired_count), 32'd0);

        // release reset; first cycle still HALT, then 0001,0010,0100,1000,0001
        rst_n = 1'b1;
        cycle(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b1, 1'b0);
        check("rr_count", 32'(mif.io_fired_count), 32'd5);

        // skip and wrap: land ptr at 3, then guard 0101
        cycle(4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(4'b0101, 1'b1, 1'b0);

        // halt and single step
        cycle(4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        check("halt_state", 32'(mif.io_state), 32'd0);

        // random mix of guards, run and step
        for (int i = 0; i < 300; i++) begin
            cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 1)));
        end
        check("sat_stop", 32'(sif.io_fired_count), 32'((m_cnt > 15) ? 15 : m_cnt));

        // near-deadlock: 7 idle cycles then a live guard
        cycle(4'b1000, 1'b1, 1'b0);
        for (int i = 0; i < LIMIT - 1; i++) cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0);
        check("no_deadlock", 32'(mif.io_deadlock), 32'(m_mode == 2));

        // full deadlock, then DEAD ignores run and step
        for (int i = 0; i < LIMIT; i++) cycle(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b1, 1'b1);
        check("dead_state", 32'(mif.io_state), 32'd2);
        check("dead_flag", 32'(mif.io_deadlock), 32'd1);

        // asynchronous reset mid-cycle
        guard = 4'b1111;
        run   = 1'b1;
        step  = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_en_a", 32'(mif.io_en_a), 32'd0);
        check("async_state", 32'(mif.io_state), 32'd0);
        check("async_count", 32'(mif.io_fired_count), 32'd0);
        check("async_dead", 32'(mif.io_deadlock), 32'd0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        cycle(4'b0110, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(4'b0110, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) cycle(4'($urandom_range(1, 15)), 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
